// File: rtl/neuron_loader.sv
// neuron_loader
//   Collects byte-serial frames into a SYNAPSES-wide staging vector and commits
//   them either to the neuron's weights or to its input spikes. A completed
//   input frame is followed by a single-cycle step pulse that enables the neuron.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : synchronous, active-high
//   in_data          : frame byte
//   in_valid         : in_data is valid
//   in_ready         : loader accepts a byte this cycle
//   frame_is_weights : frame type, sampled with the first byte only (1 = weights)
//   abort            : discard the partial frame (ignored during STEP)
//   weights          : committed weight vector
//   inputs           : committed input spike vector
//   step             : one-cycle neuron enable after an input frame
//   busy             : frame partially received or step pending
module neuron_loader #(
    parameter int SYNAPSES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                frame_is_weights,
    input  logic                abort,
    output logic [SYNAPSES-1:0] weights,
    output logic [SYNAPSES-1:0] inputs,
    output logic                step,
    output logic                busy
);

    localparam int BYTES = SYNAPSES / 8;
    localparam int CW    = $clog2(BYTES + 1);

    typedef enum logic [1:0] {IDLE, RECV, STEP} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [SYNAPSES-1:0] stage, stage_nxt, stage_ins;
    logic                is_w, is_w_nxt;
    logic                accept, last, frame_w;
    logic                commit_w, commit_i;

    // Gating with reset keeps the handshake and status quiet while reset is held,
    // so a step that was pending when reset arrived never shows up.
    assign in_ready = (state != STEP) && !reset;
    assign accept   = in_valid && in_ready && !abort;
    assign step     = (state == STEP) && !reset;
    assign busy     = ((state == RECV) || (state == STEP)) && !reset;

    // Frame type comes from the live input on the first byte, else the latched copy.
    assign frame_w  = (state == IDLE) ? frame_is_weights : is_w;
    assign last     = (cnt == CW'(BYTES - 1));

    // Staging vector with the current byte dropped into its slot.
    always_comb begin
        stage_ins = stage;
        for (int b = 0; b < BYTES; b++) begin
            if (cnt == CW'(b)) stage_ins[b*8 +: 8] = in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stage_nxt = stage;
        is_w_nxt  = is_w;
        commit_w  = 1'b0;
        commit_i  = 1'b0;
        case (state)
            IDLE, RECV: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end else if (accept) begin
                    if (last) begin
                        commit_w  = frame_w;
                        commit_i  = !frame_w;
                        cnt_nxt   = '0;
                        stage_nxt = '0;
                        state_nxt = frame_w ? IDLE : STEP;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        stage_nxt = stage_ins;
                        state_nxt = RECV;
                        if (state == IDLE) is_w_nxt = frame_is_weights;
                    end
                end
            end
            STEP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            stage   <= '0;
            is_w    <= 1'b0;
            weights <= '0;
            inputs  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            stage <= stage_nxt;
            is_w  <= is_w_nxt;
            if (commit_w) weights <= stage_ins;
            if (commit_i) inputs  <= stage_ins;
        end
    end

endmodule

// File: tb/tb_neuron_loader.sv
module tb_neuron_loader;

    localparam int SYN = 32;
    localparam int NB  = SYN / 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [7:0]     in_data = '0;
    logic           in_valid = 1'b0;
    logic           frame_is_weights = 1'b0;
    logic           abort = 1'b0;
    logic           in_ready, step, busy;
    logic [SYN-1:0] weights, inputs;

    neuron_loader #(.SYNAPSES(SYN)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .frame_is_weights(frame_is_weights), .abort(abort),
        .weights(weights), .inputs(inputs), .step(step), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int steps_seen = 0;

    // Reference model: bytes of the frame in flight, its type, committed vectors,
    // and whether an input frame just completed (step owed next cycle).
    logic [7:0]     mq[$];
    logic           m_type = 1'b0;
    logic [SYN-1:0] m_w = '0;
    logic [SYN-1:0] m_i = '0;
    bit             m_pend = 1'b0;

    task automatic check(input string tag, input logic [SYN-1:0] obs, input logic [SYN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model
    // across the following rising edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic f,
                         input logic a, input logic r);
        logic [SYN-1:0] val;
        @(negedge clk);
        in_valid = v; in_data = d; frame_is_weights = f; abort = a; reset = r;
        #1;
        check("in_ready", SYN'(in_ready), SYN'(!r && !m_pend));
        check("step",     SYN'(step),     SYN'(!r && m_pend));
        check("busy",     SYN'(busy),     SYN'(!r && (m_pend || mq.size() > 0)));
        check("weights",  weights, m_w);
        check("inputs",   inputs,  m_i);
        if (step) steps_seen++;
        if (r) begin
            mq.delete(); m_w = '0; m_i = '0; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pend = 1'b0;
        end else if (a) begin
            mq.delete();
        end else if (v) begin
            if (mq.size() == 0) m_type = f;
            mq.push_back(d);
            if (mq.size() == NB) begin
                val = '0;
                foreach (mq[k]) val |= SYN'(mq[k]) << (8 * k);
                if (m_type) m_w = val;
                else begin
                    m_i = val;
                    m_pend = 1'b1;
                end
                mq.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    endtask

    // Send a frame byte by byte with 0..maxgap idle cycles before each byte;
    // frame_is_weights is random on every byte except the first.
    task automatic send_frame(input logic [SYN-1:0] word, input logic isw, input int maxgap);
        for (int k = 0; k < NB; k++) begin
            if (k > 0 && maxgap > 0) idle($urandom_range(maxgap, 0));
            cycle(1'b1, word[8*k +: 8], (k == 0) ? isw : 1'($urandom), 1'b0, 1'b0);
        end
    endtask

    initial begin
        int s0;
        // Reset held: everything quiet and zero.
        cycle(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Weight frame, no gaps; no step, inputs untouched.
        s0 = steps_seen;
        send_frame(32'h44332211, 1'b1, 0);
        idle(2);
        check("w_frame_weights", weights, 32'h44332211);
        check("w_frame_inputs",  inputs,  32'h0);
        check("w_frame_nostep",  SYN'(steps_seen - s0), SYN'(0));

        // Input frame, then a byte offered during STEP (must be refused).
        s0 = steps_seen;
        send_frame(32'h5AA500FF, 1'b0, 0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("i_frame_inputs", inputs, 32'h5AA500FF);
        idle(2);
        check("i_frame_onestep", SYN'(steps_seen - s0), SYN'(1));
        check("i_frame_busy_off", SYN'(busy), SYN'(0));

        // Input frame with random gaps.
        send_frame(32'h5AA500FF ^ 32'h0F0F0F0F, 1'b0, 3);
        idle(2);
        check("gap_inputs", inputs, 32'h55AA0FF0);

        // Two bytes, abort, then a clean frame.
        s0 = steps_seen;
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
        send_frame(32'h04030201, 1'b0, 0);
        idle(2);
        check("abort_inputs", inputs, 32'h04030201);
        check("abort_onestep", SYN'(steps_seen - s0), SYN'(1));

        // Reset mid weight frame.
        send_frame(32'hDEADBEEF, 1'b1, 1);
        idle(1);
        check("pre_reset_w", weights, 32'hDEADBEEF);
        s0 = steps_seen;
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'h10 + k), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("reset_w", weights, 32'h0);
        send_frame(32'hCAFEF00D, 1'b1, 0);
        idle(1);
        check("post_reset_w", weights, 32'hCAFEF00D);
        check("reset_nostep", SYN'(steps_seen - s0), SYN'(0));

        // Reset during STEP suppresses the pulse.
        send_frame(32'h13579BDF, 1'b0, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);

        // frame_is_weights toggled on later bytes of an input frame.
        s0 = steps_seen;
        for (int k = 0; k < NB; k++) cycle(1'b1, 8'(8'hA0 + k), (k == 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
        idle(2);
        check("fiw_inputs", inputs, 32'hA3A2A1A0);
        check("fiw_step", SYN'(steps_seen - s0), SYN'(1));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom % 3 != 0), 8'($urandom), 1'($urandom),
                  1'($urandom % 25 == 0), 1'($urandom % 120 == 0));
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
